// File: rtl/timing_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : timing_generator
//  Description : Triple-redundant bit-time / phase-time sequencer. Counts
//                bit times B1..B14 inside phase times PH1..PH3, one step per
//                A1RP rising edge. Each of three state copies reloads from
//                the 2-of-3 voted state, so a single corrupted copy is
//                outvoted and repaired at the following advance.
//  Revision    : 1.0  initial release
// ============================================================================
module timing_generator (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        V1,
    input  logic        A1RP,
    input  logic        SYNC,
    input  logic [1:0]  FLT_INJ,
    output logic [13:0] BT,
    output logic [2:0]  PHT,
    output logic [3:0]  BCNT,
    output logic [1:0]  PCNT,
    output logic        CYC_STB,
    output logic        TMR_ERR
);

    localparam logic [3:0] c_bit_first = 4'd1;
    localparam logic [3:0] c_bit_last  = 4'd14;
    localparam logic [1:0] c_ph_first  = 2'd1;
    localparam logic [1:0] c_ph_last   = 2'd3;

    logic [3:0] r_bit [3];
    logic [1:0] r_ph  [3];
    logic       r_a1rp_d;
    logic       r_v1_d;

    logic       w_adv;
    logic [3:0] w_vbit;
    logic [1:0] w_vph;
    logic       w_valid;
    logic [3:0] w_nbit;
    logic [1:0] w_nph;
    logic       w_wrap;
    logic [3:0] w_dbit;
    logic [1:0] w_dph;
    logic [2:0] w_flt;
    logic       w_diff;

    // A level already high when supply returns must not look like an edge,
    // so the first clock after V1 comes back is never an advance.
    assign w_adv = V1 & r_v1_d & A1RP & ~r_a1rp_d;

    // Bitwise 2-of-3 majority of the state copies.
    assign w_vbit = (r_bit[0] & r_bit[1]) | (r_bit[0] & r_bit[2]) | (r_bit[1] & r_bit[2]);
    assign w_vph  = (r_ph[0]  & r_ph[1])  | (r_ph[0]  & r_ph[2])  | (r_ph[1]  & r_ph[2]);

    assign w_valid = (w_vbit >= c_bit_first) && (w_vbit <= c_bit_last) &&
                     (w_vph  >= c_ph_first);

    // Unreachable encodings are shown as B1/PH1 so the decodes stay one-hot.
    assign w_dbit = w_valid ? w_vbit : c_bit_first;
    assign w_dph  = w_valid ? w_vph  : c_ph_first;

    assign w_diff = (r_bit[0] != r_bit[1]) || (r_bit[0] != r_bit[2]) ||
                    (r_ph[0]  != r_ph[1])  || (r_ph[0]  != r_ph[2]);

    // Next voted state: realign, recover from bad encodings, or step.
    always_comb begin
        w_nbit = c_bit_first;
        w_nph  = c_ph_first;
        w_wrap = 1'b0;
        if (!SYNC && w_valid) begin
            if (w_vbit != c_bit_last) begin
                w_nbit = w_vbit + 4'd1;
                w_nph  = w_vph;
            end else if (w_vph == c_ph_last) begin
                w_wrap = 1'b1;
            end else begin
                w_nph = w_vph + 2'd1;
            end
        end
    end

    // Select which copy (if any) receives the corrupted bit-count LSB.
    always_comb begin
        w_flt = 3'b000;
        case (FLT_INJ)
            2'd1:    w_flt = 3'b001;
            2'd2:    w_flt = 3'b010;
            2'd3:    w_flt = 3'b100;
            default: w_flt = 3'b000;
        endcase
    end

    // Edge detector history and supply-return guard; frozen while V1 is low.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_a1rp_d <= 1'b0;
            r_v1_d   <= 1'b0;
        end else begin
            r_v1_d <= V1;
            if (V1) begin
                r_a1rp_d <= A1RP;
            end
        end
    end

    // Three state copies, all loaded from the voted next value.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            for (int i = 0; i < 3; i++) begin
                r_bit[i] <= c_bit_first;
                r_ph[i]  <= c_ph_first;
            end
        end else if (w_adv) begin
            for (int i = 0; i < 3; i++) begin
                r_bit[i] <= w_nbit ^ {3'b000, w_flt[i]};
                r_ph[i]  <= w_nph;
            end
        end
    end

    // Registered decodes of the voted state, cycle strobe and sticky error.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            BT      <= 14'h0001;
            PHT     <= 3'b001;
            BCNT    <= c_bit_first;
            PCNT    <= c_ph_first;
            CYC_STB <= 1'b0;
            TMR_ERR <= 1'b0;
        end else if (V1) begin
            BT      <= 14'd1 << (w_dbit - 4'd1);
            PHT     <= 3'd1 << (w_dph - 2'd1);
            BCNT    <= w_dbit;
            PCNT    <= w_dph;
            CYC_STB <= w_adv & w_wrap;
            TMR_ERR <= TMR_ERR | w_diff;
        end else begin
            CYC_STB <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timing_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timing_generator
//  Description : Directed self-checking bench for timing_generator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timing_generator;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b0;
    logic        V1      = 1'b1;
    logic        A1RP    = 1'b0;
    logic        SYNC    = 1'b0;
    logic [1:0]  FLT_INJ = 2'd0;
    logic [13:0] BT;
    logic [2:0]  PHT;
    logic [3:0]  BCNT;
    logic [1:0]  PCNT;
    logic        CYC_STB;
    logic        TMR_ERR;

    int errors = 0;
    int checks = 0;

    int   stb_hi   = 0;
    int   stb_rise = 0;
    logic stb_prev = 1'b0;

    timing_generator dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .V1      (V1),
        .A1RP    (A1RP),
        .SYNC    (SYNC),
        .FLT_INJ (FLT_INJ),
        .BT      (BT),
        .PHT     (PHT),
        .BCNT    (BCNT),
        .PCNT    (PCNT),
        .CYC_STB (CYC_STB),
        .TMR_ERR (TMR_ERR)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // Count strobe clocks and strobe pulses, sampled away from the active edge.
    always @(negedge SIM_CLK) begin
        if (CYC_STB === 1'b1) begin
            stb_hi++;
            if (stb_prev !== 1'b1) stb_rise++;
        end
        stb_prev = CYC_STB;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int b, input int p);
        logic [15:0] one = 16'd1;
        check({tag, " BCNT"}, 16'(BCNT), 16'(b));
        check({tag, " PCNT"}, 16'(PCNT), 16'(p));
        check({tag, " BT"},   16'(BT),   one << (b - 1));
        check({tag, " PHT"},  16'(PHT),  one << (p - 1));
    endtask

    // One full A1RP period; called and returning on a negedge.
    task automatic do_edge();
        A1RP = 1'b1;
        repeat (4) @(negedge SIM_CLK);
        A1RP = 1'b0;
        repeat (4) @(negedge SIM_CLK);
    endtask

    task automatic do_edges(input int n);
        for (int k = 0; k < n; k++) do_edge();
    endtask

    task automatic reset_dut();
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        repeat (3) @(negedge SIM_CLK);
        SIM_RST = 1'b0;
        @(negedge SIM_CLK);
    endtask

    initial begin
        int h0;
        int r0;

        // Reset values
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        repeat (3) @(negedge SIM_CLK);
        check_state("reset", 1, 1);
        check("reset CYC_STB", 16'(CYC_STB), 16'd0);
        check("reset TMR_ERR", 16'(TMR_ERR), 16'd0);
        SIM_RST = 1'b0;
        @(negedge SIM_CLK);

        // Walk through 14 bit times
        for (int i = 1; i <= 14; i++) begin
            do_edge();
            if (i < 14) check_state($sformatf("walk%0d", i), i + 1, 1);
            else        check_state("walk14", 1, 2);
        end
        check("walk no strobe", 16'(stb_hi), 16'd0);

        // Full computer cycle: 42 edges give one single-clock strobe
        reset_dut();
        h0 = stb_hi;
        r0 = stb_rise;
        do_edges(41);
        check_state("cyc41", 14, 3);
        check("cyc41 no strobe", 16'(stb_hi - h0), 16'd0);
        do_edge();
        check("cyc42 pulses", 16'(stb_rise - r0), 16'd1);
        check("cyc42 width", 16'(stb_hi - h0), 16'd1);
        check_state("cyc42", 1, 1);

        // SYNC at B9/PH2 realigns without a strobe; SYNC alone does nothing
        reset_dut();
        do_edges(22);
        check_state("pre sync", 9, 2);
        h0 = stb_hi;
        SYNC = 1'b1;
        do_edge();
        SYNC = 1'b0;
        check_state("sync", 1, 1);
        check("sync no strobe", 16'(stb_hi - h0), 16'd0);
        do_edges(3);
        SYNC = 1'b1;
        repeat (6) @(negedge SIM_CLK);
        SYNC = 1'b0;
        @(negedge SIM_CLK);
        check_state("sync idle", 4, 1);
        do_edge();
        check_state("after sync idle", 5, 1);

        // Fault injected into copy 2 at B5 is outvoted and flagged
        reset_dut();
        do_edges(4);
        check_state("pre flt", 5, 1);
        check("pre flt TMR_ERR", 16'(TMR_ERR), 16'd0);
        FLT_INJ = 2'd2;
        do_edge();
        FLT_INJ = 2'd0;
        check("flt BCNT", 16'(BCNT), 16'd6);
        check("flt TMR_ERR", 16'(TMR_ERR), 16'd1);
        do_edge();
        check("reconv BCNT", 16'(BCNT), 16'd7);
        check("reconv TMR_ERR", 16'(TMR_ERR), 16'd1);
        do_edges(2);
        check("sticky TMR_ERR", 16'(TMR_ERR), 16'd1);

        // Supply loss at B7 freezes; a high A1RP on return is not an edge
        reset_dut();
        check("rst clears TMR_ERR", 16'(TMR_ERR), 16'd0);
        do_edges(6);
        check_state("pre v1", 7, 1);
        V1 = 1'b0;
        do_edges(3);
        check_state("v1 low", 7, 1);
        check("v1 low CYC_STB", 16'(CYC_STB), 16'd0);
        A1RP = 1'b1;
        repeat (2) @(negedge SIM_CLK);
        V1 = 1'b1;
        repeat (4) @(negedge SIM_CLK);
        check_state("v1 return high", 7, 1);
        A1RP = 1'b0;
        repeat (4) @(negedge SIM_CLK);
        do_edge();
        check_state("v1 next edge", 8, 1);

        // Reset at B12/PH3 wins over a coincident A1RP rise
        reset_dut();
        do_edges(39);
        check_state("pre rst", 12, 3);
        A1RP    = 1'b1;
        SIM_RST = 1'b1;
        repeat (3) @(negedge SIM_CLK);
        check_state("mid rst", 1, 1);
        check("mid rst CYC_STB", 16'(CYC_STB), 16'd0);
        SIM_RST = 1'b0;
        A1RP    = 1'b0;
        repeat (2) @(negedge SIM_CLK);
        check_state("post rst idle", 1, 1);
        do_edge();
        check_state("post rst edge", 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timing_generator.md
TIMING_GENERATOR -- requirements
Module: timing_generator

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of SIM_CLK.
REQ-002 SIM_CLK  input  1  simulation clock.
REQ-003 SIM_RST  input  1  synchronous active-high reset.
REQ-004 V1  input  1  logic supply-good; 0 = hold all state.
REQ-005 A1RP  input  1  bit-time phase level from clock logic; one full period = one bit time.
REQ-006 SYNC  input  1  realign request; applied at the next bit-time advance.
REQ-007 FLT_INJ  input  2  fault injection: 0 = none, 1..3 = corrupt counter copy 1..3.
REQ-008 BT  output  14  one-hot bit time; bit0 = B1 ... bit13 = B14.
REQ-009 PHT  output  3  one-hot phase time; bit0 = PH1, bit1 = PH2, bit2 = PH3.
REQ-010 BCNT  output  4  binary bit time, 1..14.
REQ-011 PCNT  output  2  binary phase time, 1..3.
REQ-012 CYC_STB  output  1  one-clock pulse at the end of each computer cycle.
REQ-013 TMR_ERR  output  1  sticky flag; counter copies have disagreed.

Function
REQ-014 SHALL register A1RP once as A1RP_D; advance = V1 & A1RP & ~A1RP_D, i.e. one advance per A1RP rising edge.
REQ-015 SHALL hold three independent copies of {bit 1..14, phase 1..3}; each copy's next value SHALL be computed from the bitwise 2-of-3 majority-voted state, never from its own state alone.
REQ-016 Normal advance: bit < 14 -> bit+1, phase unchanged; bit = 14 -> bit = 1 and phase+1; bit = 14 and phase = 3 -> bit = 1, phase = 1.
REQ-017 CYC_STB SHALL be 1 for exactly the one clock following the advance that wraps B14/PH3 to B1/PH1; otherwise 0.
REQ-018 SYNC = 1 at an advance SHALL load B1/PH1 into all copies instead of incrementing, and SHALL NOT assert CYC_STB; SYNC without an advance SHALL have no effect.
REQ-019 FLT_INJ = n (1..3) at an advance SHALL load copy n with the voted next value XOR 1 on the bit-count LSB; the other copies load the correct value.
REQ-020 BT, PHT, BCNT and PCNT SHALL be registered decodes of the voted state, updating in the clock after the advance edge (latency 1 clock from the A1RP rising-edge sample).
REQ-021 TMR_ERR SHALL set in the clock after any two copies differ and stay set until SIM_RST.
REQ-022 V1 = 0 SHALL freeze the counters, the outputs and A1RP_D, and SHALL force CYC_STB to 0; on return to V1 = 1 an A1RP level already high SHALL NOT count as an edge.
REQ-023 BT and PHT SHALL always be exactly one-hot; unreachable voted encodings (bit 0 or 15, phase 0) SHALL decode and load as B1/PH1 at the next advance.
REQ-024 SIM_RST SHALL take priority over SYNC, V1 and advance.

Reset
REQ-025 SIM_RST = 1 SHALL set all copies to B1/PH1, A1RP_D = 0, BT = 14'h0001, PHT = 3'b001, BCNT = 1, PCNT = 1, CYC_STB = 0 and TMR_ERR = 0.
REQ-026 Reset asserted mid-cycle SHALL abandon the current count; the first advance after release SHALL produce B2/PH1.

Verification
REQ-027 After reset, 14 A1RP edges -> BCNT 2..14 then 1, PCNT 1 -> 2, BT walks bit1 -> bit13 -> bit0.
REQ-028 42 A1RP edges from reset -> exactly one CYC_STB pulse, one clock wide, after the 42nd edge; state B1/PH1.
REQ-029 SYNC held during the edge at B9/PH2 -> B1/PH1 next clock, CYC_STB stays 0.
REQ-030 FLT_INJ = 2 on one edge at B5 -> BCNT = 6 (outvoted), TMR_ERR = 1 next clock, copies reconverge at the next edge, TMR_ERR stays 1.
REQ-031 V1 = 0 across 3 A1RP periods at B7 -> BCNT stays 7; V1 = 1 with A1RP high -> no advance until the next rising edge.
REQ-032 SIM_RST at B12/PH3 with A1RP rising in the same clock -> reset values; the next edge gives BCNT = 2.
